seq_booth_mul: RTL and testbench

- Parametrised, multi-cycle signed multiplier; successor to the combinational `mul` block.
- Computes `P = inputA * inputB` (two's complement) with radix-2 Booth recoding, one multiplier bit per clock.
- Valid/ready handshakes on input and output let it sit in a streaming DSP datapath and tolerate downstream backpressure.
- Trades throughput for area: one adder of width `BIT_A+1` instead of a full array.

---
 rtl/seq_booth_mul.sv | 113 +++++++++++
 tb/tb_seq_booth_mul.sv | 211 +++++++++++++++++++++
 2 files changed

// File: rtl/seq_booth_mul.sv
// rtl/seq_booth_mul.sv - multi-cycle radix-2 Booth signed multiplier with valid/ready handshakes
module seq_booth_mul #(
  parameter int BIT_A = 5,
  parameter int BIT_B = 7
) (
  input  logic                            clk,
  input  logic                            rst_n,
  input  logic                            in_valid,
  output logic                            in_ready,
  input  logic signed [BIT_A-1:0]         inputA,
  input  logic signed [BIT_B-1:0]         inputB,
  output logic                            out_valid,
  input  logic                            out_ready,
  output logic signed [BIT_A+BIT_B-1:0]   P,
  output logic                            busy
);

  localparam int CW = $clog2(BIT_B + 1);

  typedef enum logic [1:0] {IDLE, CALC, DONE} state_t;

  state_t            state;
  state_t            state_nxt;

  logic [BIT_A-1:0]  a_reg;
  logic [BIT_A:0]    acc;
  logic [BIT_B-1:0]  q;
  logic              q_1;
  logic [CW-1:0]     count;

  logic [BIT_A:0]    a_ext;
  logic [BIT_A:0]    acc_sum;
  logic [BIT_A:0]    acc_shf;
  logic [BIT_B-1:0]  q_shf;
  logic              last_step;

  // One Booth step: add/subtract the sign-extended multiplicand, then shift {acc, q, q_1} right arithmetically
  always_comb begin
    a_ext = {a_reg[BIT_A-1], a_reg};
    case ({q[0], q_1})
      2'b01:   acc_sum = acc + a_ext;
      2'b10:   acc_sum = acc - a_ext;
      default: acc_sum = acc;
    endcase
    acc_shf   = {acc_sum[BIT_A], acc_sum[BIT_A:1]};
    q_shf     = {acc_sum[0], q[BIT_B-1:1]};
    last_step = (count == CW'(BIT_B - 1));
  end

  // Next-state and handshake outputs, decoded purely from the current state
  always_comb begin
    state_nxt = state;
    in_ready  = 1'b0;
    out_valid = 1'b0;
    busy      = 1'b0;
    case (state)
      IDLE: begin
        in_ready = 1'b1;
        if (in_valid) state_nxt = CALC;
      end
      CALC: begin
        busy = 1'b1;
        if (last_step) state_nxt = DONE;
      end
      DONE: begin
        busy      = 1'b1;
        out_valid = 1'b1;
        if (out_ready) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  // State register
  always_ff @(posedge clk) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  // Operand capture, iterative Booth datapath and product register
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      a_reg <= '0;
      acc   <= '0;
      q     <= '0;
      q_1   <= 1'b0;
      count <= '0;
      P     <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (in_valid) begin
            a_reg <= inputA;
            acc   <= '0;
            q     <= inputB;
            q_1   <= 1'b0;
            count <= '0;
          end
        end
        CALC: begin
          acc   <= acc_shf;
          q     <= q_shf;
          q_1   <= q[0];
          count <= count + CW'(1);
          // the top accumulator bit is only a guard bit; the low BIT_A+BIT_B bits are exact
          if (last_step) P <= {acc_shf[BIT_A-1:0], q_shf};
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_seq_booth_mul.sv
// tb/tb_seq_booth_mul.sv - self-checking bench for seq_booth_mul against an A*B reference
module tb_seq_booth_mul;

  logic clk;
  logic rst_n;

  logic               in_valid0, in_ready0, out_valid0, out_ready0, busy0;
  logic signed [4:0]  inputA0;
  logic signed [6:0]  inputB0;
  logic signed [11:0] p0;

  logic               in_valid1, in_ready1, out_valid1, out_ready1, busy1;
  logic signed [7:0]  inputA1;
  logic signed [7:0]  inputB1;
  logic signed [15:0] p1;

  int compared;
  int mismatched;

  seq_booth_mul #(.BIT_A(5), .BIT_B(7)) dut0 (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid0), .in_ready(in_ready0),
    .inputA(inputA0), .inputB(inputB0), .out_valid(out_valid0),
    .out_ready(out_ready0), .P(p0), .busy(busy0)
  );

  seq_booth_mul #(.BIT_A(8), .BIT_B(8)) dut1 (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid1), .in_ready(in_ready1),
    .inputA(inputA1), .inputB(inputB1), .out_valid(out_valid1),
    .out_ready(out_ready1), .P(p1), .busy(busy1)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic signed [63:0] obs, input logic signed [63:0] exp);
    compared++;
    assert (obs === exp) else begin
      mismatched++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  // full transaction on the 5x7 instance with out_ready held high
  task automatic op0(input int a, input int b);
    int cyc;
    longint expv;
    expv = longint'(a) * longint'(b);
    inputA0   = a[4:0];
    inputB0   = b[6:0];
    in_valid0 = 1'b1;
    check("in_ready0_pre", in_ready0, 1);
    tick;
    in_valid0 = 1'b0;
    cyc = 0;
    do begin
      tick;
      cyc++;
    end while (!out_valid0 && cyc < 40);
    check("latency0", cyc, 7);
    check("product0", p0, expv);
    tick;
  endtask

  // full transaction on the 8x8 instance with out_ready held high
  task automatic op1(input int a, input int b);
    int cyc;
    longint expv;
    expv = longint'(a) * longint'(b);
    inputA1   = a[7:0];
    inputB1   = b[7:0];
    in_valid1 = 1'b1;
    check("in_ready1_pre", in_ready1, 1);
    tick;
    in_valid1 = 1'b0;
    cyc = 0;
    do begin
      tick;
      cyc++;
    end while (!out_valid1 && cyc < 40);
    check("latency1", cyc, 8);
    check("product1", p1, expv);
    tick;
  endtask

  initial begin
    int  cyc;
    bit  seen;
    logic signed [7:0] ra;
    logic signed [7:0] rb;
    compared   = 0;
    mismatched = 0;
    rst_n      = 1'b0;
    in_valid0  = 1'b0; out_ready0 = 1'b0; inputA0 = '0; inputB0 = '0;
    in_valid1  = 1'b0; out_ready1 = 1'b0; inputA1 = '0; inputB1 = '0;

    // reset values
    tick;
    tick;
    check("rst_in_ready0", in_ready0, 1);
    check("rst_out_valid0", out_valid0, 0);
    check("rst_busy0", busy0, 0);
    check("rst_p0", p0, 0);
    check("rst_in_ready1", in_ready1, 1);
    check("rst_p1", p1, 0);
    rst_n      = 1'b1;
    out_ready0 = 1'b1;
    out_ready1 = 1'b1;
    seen = 1'b0;
    for (int i = 0; i < 10; i++) begin
      tick;
      if (out_valid0 || out_valid1) seen = 1'b1;
    end
    check("idle_no_out_valid", seen, 0);

    // basic products and extremes
    op0(3, 5);
    op0(-7, 9);
    op0(-16, -64);
    op0(-16, 63);
    op0(15, -64);

    // backpressure: result held while out_ready is low
    out_ready0 = 1'b0;
    inputA0 = 5'sd11;
    inputB0 = -7'sd23;
    in_valid0 = 1'b1;
    tick;
    in_valid0 = 1'b0;
    cyc = 0;
    do begin
      tick;
      cyc++;
    end while (!out_valid0 && cyc < 40);
    check("bp_latency", cyc, 7);
    for (int i = 0; i < 5; i++) begin
      tick;
      check("bp_out_valid", out_valid0, 1);
      check("bp_p", p0, -253);
      check("bp_in_ready", in_ready0, 0);
    end
    out_ready0 = 1'b1;
    tick;
    check("bp_release_out_valid", out_valid0, 0);
    check("bp_release_in_ready", in_ready0, 1);
    check("bp_release_busy", busy0, 0);

    // reset on the third compute edge discards the operation
    inputA0 = 5'sd12;
    inputB0 = 7'sd12;
    in_valid0 = 1'b1;
    tick;
    in_valid0 = 1'b0;
    tick;
    tick;
    rst_n = 1'b0;
    tick;
    rst_n = 1'b1;
    check("midrst_in_ready", in_ready0, 1);
    check("midrst_busy", busy0, 0);
    check("midrst_out_valid", out_valid0, 0);
    check("midrst_p", p0, 0);
    seen = 1'b0;
    for (int i = 0; i < 10; i++) begin
      tick;
      if (out_valid0) seen = 1'b1;
    end
    check("midrst_no_out_valid", seen, 0);
    op0(2, 3);

    // reset coinciding with a handshake drops the operands
    inputA0 = 5'sd5;
    inputB0 = 7'sd5;
    in_valid0 = 1'b1;
    rst_n = 1'b0;
    tick;
    rst_n = 1'b1;
    in_valid0 = 1'b0;
    check("rst_hs_busy", busy0, 0);
    check("rst_hs_in_ready", in_ready0, 1);
    tick;
    check("rst_hs_busy_next", busy0, 0);

    // exhaustive sweep of the 5x7 instance
    for (int a = -16; a < 16; a++) begin
      for (int b = -64; b < 64; b++) begin
        op0(a, b);
      end
    end

    // 8x8 instance: corners then random operands
    op1(-128, -128);
    op1(127, -128);
    op1(-128, 127);
    op1(127, 127);
    op1(0, -1);
    for (int i = 0; i < 400; i++) begin
      ra = 8'($urandom);
      rb = 8'($urandom);
      op1(int'(ra), int'(rb));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
